// File: rtl/instr_mem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   imem_state_e   : loader / clear-sweep FSM states (3 bits)
//   DEF_FILL_WORD  : default word written by the clear sweep
//   NOP_WORD       : NOP encoding of the 16-bit CPU
//   BYTES_PER_WORD : UART bytes per instruction word at the default width
package instr_mem_pkg;

    localparam int          DEF_DATA_W     = 16;
    localparam logic [15:0] DEF_FILL_WORD  = 16'hFFFF;
    localparam logic [15:0] NOP_WORD       = 16'h0000;
    localparam int          BYTES_PER_WORD = DEF_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ADDR_H = 3'd2,
        ST_ADDR_L = 3'd3,
        ST_CNT_H  = 3'd4,
        ST_CNT_L  = 3'd5,
        ST_DATA   = 3'd6,
        ST_DONE   = 3'd7
    } imem_state_e;

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs UART bytes (MSB first) into DATA_W-bit words.
//   clk_i        : clock
//   reset_i      : synchronous active-low reset
//   clr_i        : drop any partial word (new load transaction)
//   byte_valid_i : byte_i belongs to the current word
//   byte_i       : incoming byte
//   word_o       : assembled word, valid together with word_valid_o
//   word_valid_o : high in the cycle the last byte of a word arrives
module imem_byte_assembler
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int BPW = DATA_W / 8;

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last;

    // Word as it looks once byte_i is shifted in; older bytes fall off the top.
    assign word_o       = DATA_W'({sh_q, byte_i});
    assign last         = (cnt_q == 8'(BPW - 1));
    assign word_valid_o = byte_valid_i && last && !clr_i;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (byte_valid_i) begin
            sh_d  = word_o;
            cnt_d = last ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory with UART loader and clear sweep.
//   clk_i, reset_i       : clock, synchronous active-low reset
//   pc_i, fetch_en_i     : fetch request (accepted only in IDLE)
//   instruction_o        : registered fetch data, instr_valid_o one cycle after accept
//   mem_ready_o          : clear sweep finished
//   load_start_i         : start a load (accepted only in IDLE)
//   rx_valid_i, rx_data_i: UART byte stream
//   load_busy_o          : loader active
//   load_done_o          : one-cycle pulse at end of load
//   load_err_o           : sticky address overflow flag
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = 12,
    parameter int                PC_W      = 16,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DEF_FILL_WORD)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              fetch_en_i,
    output logic [DATA_W-1:0] instruction_o,
    output logic              instr_valid_o,
    output logic              mem_ready_o,
    input  logic              load_start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] instr_q;
    logic              ivld_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    logic              start_acc, fetch_acc, pc_oor, addr_oor;
    logic [DATA_W-1:0] asm_word;
    logic              asm_word_vld;

    assign start_acc = (state_q == ST_IDLE) && load_start_i;
    assign fetch_acc = (state_q == ST_IDLE) && fetch_en_i;
    assign pc_oor    = (pc_i >> ADDR_W) != '0;
    assign addr_oor  = (addr_q >> ADDR_W) != '0;

    imem_byte_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clr_i        (start_acc),
        .byte_valid_i (rx_valid_i && (state_q == ST_DATA)),
        .byte_i       (rx_data_i),
        .word_o       (asm_word),
        .word_valid_o (asm_word_vld)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ready_d = ready_q;
        we      = 1'b0;
        waddr   = sweep_q;
        wdata   = FILL_WORD;
        unique case (state_q)
            ST_CLEAR: begin
                we      = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (&sweep_q) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: if (load_start_i) begin
                err_d   = 1'b0;
                state_d = ST_ADDR_H;
            end
            ST_ADDR_H: if (rx_valid_i) begin
                addr_d[15:8] = rx_data_i;
                state_d      = ST_ADDR_L;
            end
            ST_ADDR_L: if (rx_valid_i) begin
                addr_d[7:0] = rx_data_i;
                state_d     = ST_CNT_H;
            end
            ST_CNT_H: if (rx_valid_i) begin
                cnt_d[15:8] = rx_data_i;
                state_d     = ST_CNT_L;
            end
            ST_CNT_L: if (rx_valid_i) begin
                cnt_d   = {cnt_q[15:8], rx_data_i};
                state_d = ({cnt_q[15:8], rx_data_i} == 16'd0) ? ST_DONE : ST_DATA;
            end
            ST_DATA: if (asm_word_vld) begin
                // Out-of-range words are consumed but dropped; the address
                // saturates so a long overflow run cannot wrap back into range.
                if (addr_oor) begin
                    err_d = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = addr_q[ADDR_W-1:0];
                    wdata = asm_word;
                end
                if (addr_q != 16'hFFFF) addr_d = addr_q + 16'd1;
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            instr_q <= FILL_WORD;
            ivld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            ivld_q  <= fetch_acc;
            // Read happens before this edge's write lands, so a fetch that
            // coincides with load_start sees the pre-load contents.
            if (fetch_acc) instr_q <= pc_oor ? FILL_WORD : mem[pc_i[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    assign instruction_o = instr_q;
    assign instr_valid_o = ivld_q;
    assign mem_ready_o   = ready_q;
    assign load_busy_o   = (state_q != ST_IDLE) && (state_q != ST_CLEAR);
    assign load_done_o   = (state_q == ST_DONE);
    assign load_err_o    = err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc = '0;
    logic        fetch_en = 1'b0;
    logic        load_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] instruction;
    logic        instr_valid, mem_ready, load_busy, load_done, load_err;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    instr_mem_loadable dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .pc_i          (pc),
        .fetch_en_i    (fetch_en),
        .instruction_o (instruction),
        .instr_valid_o (instr_valid),
        .mem_ready_o   (mem_ready),
        .load_start_i  (load_start),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .load_busy_o   (load_busy),
        .load_done_o   (load_done),
        .load_err_o    (load_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input string tag);
        pc = a; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
        chk(tag, 32'(instruction), 32'(exp));
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Bounded wait for the clear sweep; returns cycles taken.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!mem_ready && cyc < 3 * DEPTH) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        // ---- reset state
        tick(); tick();
        chk("rst_instr", 32'(instruction), 32'hFFFF);
        chk("rst_vld",   32'(instr_valid), 32'd0);
        chk("rst_ready", 32'(mem_ready),   32'd0);
        chk("rst_busy",  32'(load_busy),   32'd0);
        chk("rst_done",  32'(load_done),   32'd0);
        chk("rst_err",   32'(load_err),    32'd0);

        // ---- 1: clear sweep takes DEPTH cycles, fetch during CLEAR refused
        reset = 1'b1;
        pc = 16'd5; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("clr_fetch_vld", 32'(instr_valid), 32'd0);
        wait_ready(n);
        chk("clr_cycles", 32'(n + 1), 32'(DEPTH));
        fetch(16'd100, 16'hFFFF, "t1_f100");
        tick();
        chk("t1_vld_drop", 32'(instr_valid), 32'd0);
        chk("t1_hold", 32'(instruction), 32'hFFFF);

        // ---- 2: load two words at 100
        start();
        chk("t2_busy", 32'(load_busy), 32'd1);
        send(8'h00); send(8'h64); send(8'h00); send(8'h02);
        send(8'h0D); send(8'h00); send(8'h0D);
        chk("t2_done_early", 32'(load_done), 32'd0);
        send(8'h11);
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_err",  32'(load_err),  32'd0);
        tick();
        chk("t2_done_pulse", 32'(load_done), 32'd0);
        chk("t2_idle", 32'(load_busy), 32'd0);
        fetch(16'd100, 16'h0D00, "t2_f100");
        fetch(16'd101, 16'h0D11, "t2_f101");
        fetch(16'd102, 16'hFFFF, "t2_f102");

        // ---- 3: overflow at top of memory
        start();
        send(8'h0F); send(8'hFF); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        chk("t3_done", 32'(load_done), 32'd1);
        chk("t3_err",  32'(load_err),  32'd1);
        tick();
        chk("t3_err_sticky", 32'(load_err), 32'd1);
        fetch(16'h0FFF, 16'h1234, "t3_f4095");
        fetch(16'h1000, 16'hFFFF, "t3_f4096");
        fetch(16'h0000, 16'hFFFF, "t3_f0_nowrap");

        // ---- 4: zero-count load, clears err
        start();
        chk("t4_err_clr", 32'(load_err), 32'd0);
        send(8'h00); send(8'h64); send(8'h00);
        send(8'h00);
        chk("t4_done", 32'(load_done), 32'd1);
        tick();
        chk("t4_idle", 32'(load_busy), 32'd0);
        fetch(16'd100, 16'h0D00, "t4_f100");
        fetch(16'd101, 16'h0D11, "t4_f101");

        // ---- 5: reset in the middle of a load
        start();
        send(8'h00); send(8'h64); send(8'h00); send(8'h01); send(8'hAB);
        reset = 1'b0;
        tick();
        chk("t5_busy", 32'(load_busy), 32'd0);
        chk("t5_ready", 32'(mem_ready), 32'd0);
        reset = 1'b1;
        tick();
        wait_ready(n);
        chk("t5_clr_cycles", 32'(n + 1), 32'(DEPTH));
        fetch(16'd100, 16'hFFFF, "t5_f100");

        // ---- 6: fetch held during load, ignored second start, stray rx in IDLE
        start();
        fetch_en = 1'b1; pc = 16'd100;
        send(8'h00);
        chk("t6_vld_a", 32'(instr_valid), 32'd0);
        send(8'hC8); send(8'h00); send(8'h01);
        send(8'hBE);
        chk("t6_vld_b", 32'(instr_valid), 32'd0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t6_vld_c", 32'(instr_valid), 32'd0);
        send(8'hEF);
        chk("t6_done", 32'(load_done), 32'd1);
        chk("t6_vld_d", 32'(instr_valid), 32'd0);
        fetch_en = 1'b0;
        tick();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t6_idle_rx", 32'(load_busy), 32'd0);
        fetch(16'd200, 16'hBEEF, "t6_f200");
        fetch(16'd201, 16'hFFFF, "t6_f201");

        // ---- simultaneous fetch and load_start: fetch sees pre-load data
        pc = 16'd200; fetch_en = 1'b1; load_start = 1'b1;
        tick();
        fetch_en = 1'b0; load_start = 1'b0;
        chk("sim_vld",  32'(instr_valid), 32'd1);
        chk("sim_data", 32'(instruction), 32'hBEEF);
        chk("sim_busy", 32'(load_busy),   32'd1);
        send(8'h00); send(8'hC8); send(8'h00); send(8'h00);
        chk("sim_done", 32'(load_done), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
